// File: rtl/sram_bus_arbiter.sv
// Two-master sram-like arbiter: shares one memory port between the
// instruction-fetch and data-access masters, one transaction in flight.
module sram_bus_arbiter #(
    parameter int unsigned DATA_PRIO = 1,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic [1:0]    inst_size,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [31:0]   inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,

    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [31:0]   mem_rdata,

    output logic          busy
);

    localparam bit dataPrio = (DATA_PRIO != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } stateT;

    stateT stateQ, stateD;
    logic  ownerQ, ownerD;   // 0 = inst, 1 = data
    logic  lastQ, lastD;     // round-robin pointer: most recent grant

    logic  anyReq;
    logic  pickOwner;
    logic  ownerReq;
    logic  exitNow;

    // Arbitration decision, evaluated whenever a grant can happen.
    always_comb begin
        anyReq   = inst_req | data_req;
        ownerReq = ownerQ ? data_req : inst_req;
        if (dataPrio) begin
            pickOwner = data_req;
        end else if (inst_req && data_req) begin
            pickOwner = ~lastQ;
        end else begin
            pickOwner = data_req;
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= IDLE;
            ownerQ <= 1'b0;
            lastQ  <= 1'b1;
        end else begin
            stateQ <= stateD;
            ownerQ <= ownerD;
            lastQ  <= lastD;
        end
    end

    // Next-state logic and owner-steered request/response muxing.
    always_comb begin
        stateD       = stateQ;
        ownerD       = ownerQ;
        lastD        = lastQ;
        exitNow      = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = (stateQ != IDLE);

        case (stateQ)
            IDLE: begin
                if (anyReq) begin
                    stateD = ADDR;
                    ownerD = pickOwner;
                    lastD  = pickOwner;
                end
            end
            ADDR: begin
                if (!ownerReq) begin
                    // Owner withdrew before acceptance: issue nothing.
                    stateD = IDLE;
                end else begin
                    mem_req   = 1'b1;
                    mem_wr    = ownerQ & data_wr;
                    mem_size  = ownerQ ? data_size  : inst_size;
                    mem_addr  = ownerQ ? data_addr  : inst_addr;
                    mem_wdata = ownerQ ? data_wdata : 32'h0;
                    if (ownerQ) begin
                        data_addr_ok = mem_addr_ok;
                    end else begin
                        inst_addr_ok = mem_addr_ok;
                    end
                    if (mem_addr_ok) begin
                        if (mem_data_ok) begin
                            // Zero-latency slave: response arrives with acceptance.
                            if (ownerQ) begin
                                data_data_ok = 1'b1;
                                data_rdata   = mem_rdata;
                            end else begin
                                inst_data_ok = 1'b1;
                                inst_rdata   = mem_rdata;
                            end
                            exitNow = 1'b1;
                        end else begin
                            stateD = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (ownerQ) begin
                    data_data_ok = mem_data_ok;
                    data_rdata   = mem_rdata;
                end else begin
                    inst_data_ok = mem_data_ok;
                    inst_rdata   = mem_rdata;
                end
                exitNow = mem_data_ok;
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        // Response done: re-grant immediately if anyone is waiting.
        if (exitNow) begin
            if (anyReq) begin
                stateD = ADDR;
                ownerD = pickOwner;
                lastD  = pickOwner;
            end else begin
                stateD = IDLE;
            end
        end
    end

endmodule
